memory_cycle_sequencer: RTL and testbench
=========================================

// Module: memory_cycle_sequencer
// PURPOSE
// - Sequences one LVDC core-memory read/restore cycle per access and shares the memory module between two requesters:
//   the CPU (instruction/operand fetch, store) and the data adapter (DAD).
// - Drives the memory module's one-hot X/Y address lines, syllable selects, read/write phase lines, sync, sense strobe
//   and inhibit/restore data, and captures the sensed 14-bit syllable.
// - Sits between the CPU/DAD access logic and the memory module. One access is a destructive read followed by a
//   restore of either the sensed data (read) or the new data (store).
// PARAMETERS
// - READ_CYC   4  clocks the read phase holds sync high (>=2)
// - SENSE_AT   3  clock within the read phase (1..READ_CYC) at which sense data is sampled
// - WRITE_CYC  4  clocks the restore phase holds sync high (>=1)
// PORTS
// - clk          in   1   system clock
// - rstn         in   1   synchronous reset, active-low
// - cpu_req      in   1   CPU access request; level, held until cpu_done
// - cpu_addr     in   12  CPU word address
// - cpu_syl      in   1   CPU syllable select (0/1)
// - cpu_wr       in   1   1 = store cpu_wdata, 0 = read
// - cpu_wdata    in   14  CPU store data
// - dad_req, dad_addr, dad_syl, dad_wr, dad_wdata   in   1/12/1/1/14   DAD request, same meaning as cpu_*
// - cpu_gnt      out  1   one-clock pulse when the CPU access is accepted
// - dad_gnt      out  1   one-clock pulse when the DAD access is accepted
// - cpu_done     out  1   one-clock pulse at end of the CPU cycle
// - dad_done     out  1   one-clock pulse at end of the DAD cycle
// - rdata        out  14  syllable sensed in the last cycle; valid from done onward
// - sa           in   14  sense-amplifier outputs, bit 13 = SA1
// - ax_n, ay_n, ax0_n, ay0_n   out  8 each  active-low one-hot address drives
// - syl0_n, syl1_n   out  1   active-low syllable selects
// - rdm, rdm_n   out  1   read/write phase (complementary)
// - sync         out  1   core drive sync
// - inhbs        out  1   sense blanking; low only on the SENSE_AT clock
// - bra          out  14  inhibit/restore data
// - brov_a       out  1   high while bra is valid
// - brov_b       out  1   tied 0
// BEHAVIOUR
// - Reset, and the IDLE state, drive these values:
//   - all address lines 8'hFF; syl0_n = syl1_n = 1
//   - rdm = 0, rdm_n = 1, sync = 0, inhbs = 1
//   - bra = 0, brov_a = 0
//   - gnt/done = 0, rdata = 0
// - Reset mid-cycle abandons the cycle at once: no done is issued and the core word is lost. This is accepted.
// - States: IDLE -> SETUP(1) -> READ(READ_CYC) -> SWITCH(1) -> WRITE(WRITE_CYC) -> DONE(1) -> IDLE.
// - A 4-bit phase counter counts inside READ and WRITE.
// - IDLE arbitration:
//   - One request only: that request wins.
//   - Both requests: the requester NOT served last wins (round-robin). After reset, DAD is treated as served last,
//     so the CPU wins the first tie.
//   - The winner's gnt pulses during the IDLE->SETUP clock.
//   - addr, syl, wr and wdata are latched at that clock; later changes and dropped requests do not affect the cycle.
// - SETUP..WRITE address decode (latched values):
//   - addr[2:0] -> ax_n, addr[5:3] -> ay_n, addr[8:6] -> ax0_n, addr[11:9] -> ay0_n
//   - selected bit driven 0, all others 1
//   - syl = 0 -> syl0_n = 0; syl = 1 -> syl1_n = 0
//   - Address lines return to all-ones in DONE.
// - Phase lines:
//   - SETUP and READ: rdm = 1.
//   - SWITCH and WRITE: rdm = 0. rdm_n is always ~rdm.
//   - sync = 1 in every READ and WRITE clock, 0 in SETUP, SWITCH and DONE.
// - Sensing:
//   - On READ clock SENSE_AT, inhbs = 0 and sa is registered into a sense register.
//   - rdata is updated from the sense register on entry to DONE, for both reads and stores.
// - Restore:
//   - From SWITCH through WRITE: bra = latched wdata if wr, else the sense register; brov_a = 1.
//   - bra = 0 and brov_a = 0 elsewhere.
// - Latency: done is asserted READ_CYC + WRITE_CYC + 3 clocks after gnt (11 with defaults). Minimum spacing between
//   back-to-back accesses is 1 IDLE clock.
// - A request held high through its own done is a new request and is arbitrated again in IDLE.
// STRUCTURE
// - Shared package mem_seq_pkg holds:
//   - the state enum (IDLE, SETUP, READ, SWITCH, WRITE, DONE)
//   - default timing constants
//   - the requester id type (REQ_CPU, REQ_DAD)
// - Sub-module onehot_low_dec: 3-bit in, 8-bit active-low one-hot out, plus an enable (disabled = 8'hFF).
//   Instantiated four times.
// TESTING
// - CPU read, addr=12'o1234, syl=1:
//   - ax_n=8'hEF, ay_n=8'hF7, ax0_n=8'hFB, ay0_n=8'hFD, syl1_n=0
//   - sa=14'h2A5A at SENSE_AT -> rdata=14'h2A5A
//   - bra=14'h2A5A during WRITE; cpu_done 11 clocks after cpu_gnt
// - DAD store, addr=12'o7777, wdata=14'h1234, sa=14'h3FFF:
//   - all drives select bit 7 (8'h7F)
//   - bra=14'h1234 during WRITE; rdata=14'h3FFF
// - cpu_req and dad_req both high from reset, held:
//   - grants alternate CPU, DAD, CPU, DAD
//   - each gnt is 12 clocks apart (11 + 1 IDLE)
// - cpu_req drops and cpu_addr changes 2 clocks after cpu_gnt:
//   - the cycle completes with the original address; cpu_done still pulses
// - rstn=0 on READ clock 2:
//   - next clock all outputs at reset values; no done pulse
//   - a pending request is granted 1 clock after rstn returns to 1
// - Protocol checks: sync never high in SETUP/SWITCH/DONE; inhbs low on exactly one clock per cycle.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and default timing for the core-memory cycle sequencer.
package mem_seq_pkg;

  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned DATA_W        = 14;
  localparam int unsigned PHASE_W       = 4;
  localparam int unsigned READ_CYC_DEF  = 4;
  localparam int unsigned SENSE_AT_DEF  = 3;
  localparam int unsigned WRITE_CYC_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    READ   = 3'd2,
    SWITCH = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } seqState_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DAD = 1'b1
  } reqId_t;

  // Access parameters latched at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              syl;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } reqPayload_t;

endpackage

// File: rtl/memory_cycle_sequencer_if.sv
// Requester-side access bus: one instance each for the CPU and the data adapter.
interface memReqIf;
  import mem_seq_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              syl;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;

  modport master (output req, addr, syl, wr, wdata, input gnt, done);
  modport slave  (input req, addr, syl, wr, wdata, output gnt, done);
endinterface

// File: rtl/onehot_low_dec.sv
// 3-to-8 active-low one-hot decoder; all lines inactive (high) when disabled.
module onehot_low_dec (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] dec_c
);

  // Pull the selected line low only while enabled.
  always_comb begin
    dec_c = 8'hFF;
    if (en) dec_c[sel] = 1'b0;
  end

endmodule

// File: rtl/memory_cycle_sequencer.sv
// Core-memory read/restore cycle sequencer shared between the CPU and the data adapter.
// Every memory-side output is registered from next-state values, so gnt appears in SETUP
// and done appears in the IDLE clock that follows DONE.
module memory_cycle_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned READ_CYC  = READ_CYC_DEF,
  parameter int unsigned SENSE_AT  = SENSE_AT_DEF,
  parameter int unsigned WRITE_CYC = WRITE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  memReqIf.slave            cpu,
  memReqIf.slave            dad,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] sa,
  output logic [7:0]        ax_n,
  output logic [7:0]        ay_n,
  output logic [7:0]        ax0_n,
  output logic [7:0]        ay0_n,
  output logic              syl0_n,
  output logic              syl1_n,
  output logic              rdm,
  output logic              rdm_n,
  output logic              sync,
  output logic              inhbs,
  output logic [DATA_W-1:0] bra,
  output logic              brov_a,
  output logic              brov_b
);

  seqState_t          state, nextState;
  logic [PHASE_W-1:0] phase, nextPhase;
  reqId_t             lastServed, winner;
  logic               granting;
  reqPayload_t        cur, nextCur, cpuPay, dadPay;
  logic [DATA_W-1:0]  senseReg, senseNext;
  logic               addrEn, restoreEn, senseNow;
  logic [7:0]         axNext, ayNext, ax0Next, ay0Next;
  logic               cpuGnt, dadGnt, cpuDone, dadDone;

  assign cpuPay = '{addr: cpu.addr, syl: cpu.syl, wr: cpu.wr, wdata: cpu.wdata};
  assign dadPay = '{addr: dad.addr, syl: dad.syl, wr: dad.wr, wdata: dad.wdata};

  assign cpu.gnt  = cpuGnt;
  assign dad.gnt  = dadGnt;
  assign cpu.done = cpuDone;
  assign dad.done = dadDone;
  assign brov_b   = 1'b0;

  // Round-robin arbitration in IDLE: on a tie the requester not served last wins.
  always_comb begin
    granting = 1'b0;
    winner   = REQ_CPU;
    if (state == IDLE) begin
      if (cpu.req && dad.req) begin
        granting = 1'b1;
        if (lastServed == REQ_DAD) winner = REQ_CPU;
        else                       winner = REQ_DAD;
      end else if (cpu.req) begin
        granting = 1'b1;
        winner   = REQ_CPU;
      end else if (dad.req) begin
        granting = 1'b1;
        winner   = REQ_DAD;
      end
    end
  end

  // Next-state and phase counter sequencing.
  always_comb begin
    nextState = state;
    nextPhase = phase;
    unique case (state)
      IDLE: begin
        nextPhase = '0;
        if (granting) nextState = SETUP;
      end
      SETUP: begin
        nextState = READ;
        nextPhase = PHASE_W'(1);
      end
      READ: begin
        if (phase == PHASE_W'(READ_CYC)) begin
          nextState = SWITCH;
          nextPhase = '0;
        end else begin
          nextPhase = phase + PHASE_W'(1);
        end
      end
      SWITCH: begin
        nextState = WRITE;
        nextPhase = PHASE_W'(1);
      end
      WRITE: begin
        if (phase == PHASE_W'(WRITE_CYC)) begin
          nextState = DONE;
          nextPhase = '0;
        end else begin
          nextPhase = phase + PHASE_W'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextPhase = '0;
      end
    endcase
  end

  // Datapath next values: latched access, sense capture, drive enables.
  always_comb begin
    nextCur = cur;
    if (granting) begin
      if (winner == REQ_CPU) nextCur = cpuPay;
      else                   nextCur = dadPay;
    end
    senseNow  = (state == READ) && (phase == PHASE_W'(SENSE_AT));
    senseNext = senseNow ? sa : senseReg;
    addrEn    = nextState inside {SETUP, READ, SWITCH, WRITE};
    restoreEn = nextState inside {SWITCH, WRITE};
  end

  onehot_low_dec uDecAx  (.sel(nextCur.addr[2:0]),  .en(addrEn), .dec_c(axNext));
  onehot_low_dec uDecAy  (.sel(nextCur.addr[5:3]),  .en(addrEn), .dec_c(ayNext));
  onehot_low_dec uDecAx0 (.sel(nextCur.addr[8:6]),  .en(addrEn), .dec_c(ax0Next));
  onehot_low_dec uDecAy0 (.sel(nextCur.addr[11:9]), .en(addrEn), .dec_c(ay0Next));

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= nextState;
      phase <= nextPhase;
    end
  end

  // Latched access, sense register and round-robin history.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur        <= '0;
      senseReg   <= '0;
      lastServed <= REQ_DAD;
    end else begin
      cur      <= nextCur;
      senseReg <= senseNext;
      if (granting) lastServed <= winner;
    end
  end

  // Registered memory drives and requester handshakes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ax_n    <= 8'hFF;
      ay_n    <= 8'hFF;
      ax0_n   <= 8'hFF;
      ay0_n   <= 8'hFF;
      syl0_n  <= 1'b1;
      syl1_n  <= 1'b1;
      rdm     <= 1'b0;
      rdm_n   <= 1'b1;
      sync    <= 1'b0;
      inhbs   <= 1'b1;
      bra     <= '0;
      brov_a  <= 1'b0;
      cpuGnt  <= 1'b0;
      dadGnt  <= 1'b0;
      cpuDone <= 1'b0;
      dadDone <= 1'b0;
      rdata   <= '0;
    end else begin
      ax_n    <= axNext;
      ay_n    <= ayNext;
      ax0_n   <= ax0Next;
      ay0_n   <= ay0Next;
      syl0_n  <= !(addrEn && !nextCur.syl);
      syl1_n  <= !(addrEn && nextCur.syl);
      rdm     <= nextState inside {SETUP, READ};
      rdm_n   <= !(nextState inside {SETUP, READ});
      sync    <= nextState inside {READ, WRITE};
      inhbs   <= !((nextState == READ) && (nextPhase == PHASE_W'(SENSE_AT)));
      if (restoreEn) begin
        bra    <= nextCur.wr ? nextCur.wdata : senseNext;
        brov_a <= 1'b1;
      end else begin
        bra    <= '0;
        brov_a <= 1'b0;
      end
      cpuGnt  <= granting && (winner == REQ_CPU);
      dadGnt  <= granting && (winner == REQ_DAD);
      cpuDone <= (state == DONE) && (lastServed == REQ_CPU);
      dadDone <= (state == DONE) && (lastServed == REQ_DAD);
      if ((state == WRITE) && (nextState == DONE)) rdata <= senseReg;
    end
  end

endmodule

// File: tb/tb_memory_cycle_sequencer.sv
// Scoreboarded bench for the core-memory cycle sequencer: expected accesses are queued
// when requests are driven and checked clock by clock once the matching grant appears.
module tb_memory_cycle_sequencer;
  import mem_seq_pkg::*;

  typedef struct {
    logic              isDad;
    logic [11:0]       addr;
    logic              syl;
    logic              wr;
    logic [13:0]       wdata;
    logic [13:0]       sa;
    logic              b2b;
  } expAcc_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] sa = '0;
  logic [13:0] rdata, bra;
  logic [7:0]  ax_n, ay_n, ax0_n, ay0_n;
  logic        syl0_n, syl1_n, rdm, rdm_n, sync, inhbs, brov_a, brov_b;

  memReqIf cpuIf ();
  memReqIf dadIf ();

  memory_cycle_sequencer dut (
    .clk(clk), .rstn(rstn), .cpu(cpuIf), .dad(dadIf), .rdata(rdata), .sa(sa),
    .ax_n(ax_n), .ay_n(ay_n), .ax0_n(ax0_n), .ay0_n(ay0_n),
    .syl0_n(syl0_n), .syl1_n(syl1_n), .rdm(rdm), .rdm_n(rdm_n), .sync(sync),
    .inhbs(inhbs), .bra(bra), .brov_a(brov_a), .brov_b(brov_b)
  );

  always #5 clk = ~clk;

  int      testCount = 0;
  int      failCount = 0;
  expAcc_t expQ[$];

  // Single comparison point for every check in the bench.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    if (got !== want) begin
      failCount++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] lowHot(input logic [2:0] s);
    logic [7:0] r;
    r    = 8'hFF;
    r[s] = 1'b0;
    return r;
  endfunction

  // Clock-by-clock monitor: offset 0 is the grant clock, done is due at offset 11.
  expAcc_t cur;
  logic    active = 1'b0;
  int      cyc = 0, gntCyc = 0, lastGntCyc = 0, off = 0, senseLows = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      if (active) begin
        void'(expQ.pop_front());
        active = 1'b0;
      end
    end else begin
      if (!active && (cpuIf.gnt || dadIf.gnt)) begin
        if (expQ.size() == 0) begin
          checkVal("unexpected gnt", 32'(1), 32'(0));
        end else begin
          cur    = expQ[0];
          active = 1'b1;
          gntCyc = cyc;
          if (cur.b2b) checkVal("gnt spacing", 32'(cyc - lastGntCyc), 32'(12));
          lastGntCyc = cyc;
          senseLows  = 0;
        end
      end
      if (active) begin
        off = cyc - gntCyc;
        checkVal("gnt pulse", 32'({cpuIf.gnt, dadIf.gnt}),
                 (off == 0) ? (cur.isDad ? 32'(1) : 32'(2)) : 32'(0));
        checkVal("done pulse", 32'({cpuIf.done, dadIf.done}),
                 (off == 11) ? (cur.isDad ? 32'(1) : 32'(2)) : 32'(0));
        checkVal("sync", 32'(sync), 32'((off >= 1 && off <= 4) || (off >= 6 && off <= 9)));
        checkVal("rdm", 32'(rdm), 32'(off <= 4));
        checkVal("rdm_n", 32'(rdm_n), 32'(off > 4));
        checkVal("inhbs", 32'(inhbs), 32'(off != 3));
        checkVal("ax_n", 32'(ax_n), 32'((off <= 9) ? lowHot(cur.addr[2:0]) : 8'hFF));
        checkVal("ay_n", 32'(ay_n), 32'((off <= 9) ? lowHot(cur.addr[5:3]) : 8'hFF));
        checkVal("ax0_n", 32'(ax0_n), 32'((off <= 9) ? lowHot(cur.addr[8:6]) : 8'hFF));
        checkVal("ay0_n", 32'(ay0_n), 32'((off <= 9) ? lowHot(cur.addr[11:9]) : 8'hFF));
        checkVal("syl0_n", 32'(syl0_n), 32'(!(off <= 9 && !cur.syl)));
        checkVal("syl1_n", 32'(syl1_n), 32'(!(off <= 9 && cur.syl)));
        checkVal("brov_a", 32'(brov_a), 32'(off >= 5 && off <= 9));
        checkVal("bra", 32'(bra),
                 (off >= 5 && off <= 9) ? 32'(cur.wr ? cur.wdata : cur.sa) : 32'(0));
        checkVal("brov_b", 32'(brov_b), 32'(0));
        if (!inhbs) senseLows++;
        if (off >= 10) checkVal("rdata", 32'(rdata), 32'(cur.sa));
        if (off == 11) begin
          checkVal("sense strobes", 32'(senseLows), 32'(1));
          void'(expQ.pop_front());
          active = 1'b0;
        end
      end else begin
        checkVal("idle done", 32'({cpuIf.done, dadIf.done}), 32'(0));
        checkVal("idle sync", 32'(sync), 32'(0));
        checkVal("idle inhbs", 32'(inhbs), 32'(1));
        checkVal("idle brov_a", 32'(brov_a), 32'(0));
      end
    end
    // Memory model: valid sense data only on the sense clock, noise otherwise.
    if (active && rstn && off == 3) sa = cur.sa;
    else                            sa = 14'($urandom);
  end

  task automatic pushExp(input logic isDad, input logic [11:0] addr, input logic syl,
                         input logic wr, input logic [13:0] wdata, input logic [13:0] s,
                         input logic b2b);
    expAcc_t e;
    e.isDad = isDad; e.addr = addr; e.syl = syl; e.wr = wr;
    e.wdata = wdata; e.sa = s; e.b2b = b2b;
    expQ.push_back(e);
  endtask

  task automatic driveReq(input logic isDad, input logic [11:0] addr, input logic syl,
                          input logic wr, input logic [13:0] wdata);
    if (isDad) begin
      dadIf.addr = addr; dadIf.syl = syl; dadIf.wr = wr; dadIf.wdata = wdata; dadIf.req = 1'b1;
    end else begin
      cpuIf.addr = addr; cpuIf.syl = syl; cpuIf.wr = wr; cpuIf.wdata = wdata; cpuIf.req = 1'b1;
    end
  endtask

  task automatic waitGnt(input logic isDad);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (isDad ? dadIf.gnt : cpuIf.gnt) break;
    end
    if (n == 30) checkVal("gnt timeout", 32'(0), 32'(1));
  endtask

  task automatic waitDone(input logic isDad);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (isDad ? dadIf.done : cpuIf.done) break;
    end
    if (n == 30) checkVal("done timeout", 32'(0), 32'(1));
    if (isDad) dadIf.req = 1'b0;
    else       cpuIf.req = 1'b0;
  endtask

  task automatic checkResetOuts(input string tag);
    checkVal({tag, " addr"}, {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
    checkVal({tag, " syl"}, 32'({syl1_n, syl0_n}), 32'(3));
    checkVal({tag, " phase"}, 32'({rdm, rdm_n, sync, inhbs}), 32'(4'b0101));
    checkVal({tag, " bra"}, 32'({brov_b, brov_a, bra}), 32'(0));
    checkVal({tag, " hs"}, 32'({cpuIf.gnt, dadIf.gnt, cpuIf.done, dadIf.done}), 32'(0));
    checkVal({tag, " rdata"}, 32'(rdata), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rstn = 1'b0;
    cpuIf.req = 1'b0; cpuIf.addr = '0; cpuIf.syl = 1'b0; cpuIf.wr = 1'b0; cpuIf.wdata = '0;
    dadIf.req = 1'b0; dadIf.addr = '0; dadIf.syl = 1'b0; dadIf.wr = 1'b0; dadIf.wdata = '0;
    repeat (3) @(negedge clk);
    checkResetOuts("reset");

    // Both requesters held from reset: CPU, DAD, CPU, DAD, 12 clocks apart.
    pushExp(1'b0, 12'o0001, 1'b0, 1'b0, 14'h0000, 14'h0ABC, 1'b0);
    pushExp(1'b1, 12'o7070, 1'b1, 1'b1, 14'h0155, 14'h1111, 1'b1);
    pushExp(1'b0, 12'o0001, 1'b0, 1'b0, 14'h0000, 14'h2222, 1'b1);
    pushExp(1'b1, 12'o7070, 1'b1, 1'b1, 14'h0155, 14'h3333, 1'b1);
    driveReq(1'b0, 12'o0001, 1'b0, 1'b0, 14'h0000);
    driveReq(1'b1, 12'o7070, 1'b1, 1'b1, 14'h0155);
    rstn  = 1'b1;
    dones = 0;
    for (int n = 0; n < 80 && dones < 4; n++) begin
      @(negedge clk);
      if (cpuIf.done || dadIf.done) dones++;
    end
    cpuIf.req = 1'b0;
    dadIf.req = 1'b0;
    checkVal("round-robin dones", 32'(dones), 32'(4));
    repeat (2) @(negedge clk);

    // CPU read of 1234 octal, upper syllable.
    pushExp(1'b0, 12'o1234, 1'b1, 1'b0, 14'h0000, 14'h2A5A, 1'b0);
    driveReq(1'b0, 12'o1234, 1'b1, 1'b0, 14'h0000);
    waitGnt(1'b0);
    @(negedge clk);
    checkVal("read decode", {ax_n, ay_n, ax0_n, ay0_n}, 32'hEFF7_FBFD);
    checkVal("read syl1_n", 32'(syl1_n), 32'(0));
    waitDone(1'b0);
    checkVal("read rdata", 32'(rdata), 32'h2A5A);
    @(negedge clk);

    // DAD store to 7777 octal.
    pushExp(1'b1, 12'o7777, 1'b0, 1'b1, 14'h1234, 14'h3FFF, 1'b0);
    driveReq(1'b1, 12'o7777, 1'b0, 1'b1, 14'h1234);
    waitGnt(1'b1);
    @(negedge clk);
    checkVal("store decode", {ax_n, ay_n, ax0_n, ay0_n}, 32'h7F7F_7F7F);
    waitDone(1'b1);
    checkVal("store rdata", 32'(rdata), 32'h3FFF);
    @(negedge clk);

    // Request dropped and address changed after grant: cycle finishes with latched values.
    pushExp(1'b0, 12'o0456, 1'b0, 1'b1, 14'h0F0F, 14'h0777, 1'b0);
    driveReq(1'b0, 12'o0456, 1'b0, 1'b1, 14'h0F0F);
    waitGnt(1'b0);
    repeat (2) @(negedge clk);
    cpuIf.req = 1'b0; cpuIf.addr = 12'o5555; cpuIf.syl = 1'b1; cpuIf.wr = 1'b0; cpuIf.wdata = 14'h3C3C;
    waitDone(1'b0);
    @(negedge clk);

    // Reset on READ clock 2 abandons the cycle; the held request is granted after release.
    pushExp(1'b0, 12'o3210, 1'b1, 1'b0, 14'h0000, 14'h1ACE, 1'b0);
    driveReq(1'b0, 12'o3210, 1'b1, 1'b0, 14'h0000);
    waitGnt(1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkResetOuts("mid reset");
    @(negedge clk);
    checkVal("mid reset done", 32'({cpuIf.done, dadIf.done}), 32'(0));
    pushExp(1'b0, 12'o3210, 1'b1, 1'b0, 14'h0000, 14'h0BEE, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    checkVal("gnt after reset", 32'(cpuIf.gnt), 32'(1));
    waitDone(1'b0);
    repeat (3) @(negedge clk);

    checkVal("scoreboard drained", 32'(expQ.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
